// File: rtl/ldpc_cnu_pkg.sv
// Shared types and helpers for the serial min-sum check-node controller.
// Holds the FSM state encoding, default geometry and the magnitude extractor.
package ldpc_cnu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int W_DEF  = 6;
    localparam int DC_DEF = 8;

    // Width-agnostic: caller widens the message and slices the result.
    function automatic logic [31:0] mag_of(
        input logic [31:0] msg,
        input int          w
    );
        logic [31:0] mask;
        mask = (32'd1 << (w - 1)) - 32'd1;
        return msg & mask;
    endfunction

endpackage

// File: rtl/cnu_min_update.sv
// Combinational min1/min2/position update for one incoming magnitude.
// Strict less-than: a tie with min1 lands in min2 and keeps the earlier idx.
module cnu_min_update #(
    parameter int MW   = 5,
    parameter int IDXW = 3
) (
    input  logic [MW-1:0]   min1,
    input  logic [MW-1:0]   min2,
    input  logic [IDXW-1:0] idx,
    input  logic [MW-1:0]   mag,
    input  logic [IDXW-1:0] p,
    output logic [MW-1:0]   min1_nxt,
    output logic [MW-1:0]   min2_nxt,
    output logic [IDXW-1:0] idx_nxt
);

    always_comb begin
        min1_nxt = min1;
        min2_nxt = min2;
        idx_nxt  = idx;
        if (mag < min1) begin
            min2_nxt = min1;
            min1_nxt = mag;
            idx_nxt  = p;
        end else if (mag < min2) begin
            min2_nxt = mag;
        end
    end

endmodule

// File: rtl/cnu_serial_row_ctrl.sv
// Serial check-node controller: folds DC V2C beats into min1/min2/idx/sign.
// Optional OFFSET_MINSUM_EN applies a saturating offset at the row result.
module cnu_serial_row_ctrl
    import ldpc_cnu_pkg::*;
#(
    parameter int W      = 6,
    parameter int DC     = 8,
    parameter int IDXW   = 3,
    parameter int OFFSET = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_msg,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-2:0]    out_min1,
    output logic [W-2:0]    out_min2,
    output logic [IDXW-1:0] out_idx,
    output logic            out_sign,
    output logic            busy
);

    localparam int MW = W - 1;

    state_t          state;
    state_t          state_nxt;
    logic [IDXW-1:0] count;
    logic [MW-1:0]   min1;
    logic [MW-1:0]   min2;
    logic [IDXW-1:0] idx;
    logic            sign;

    logic            accept;
    logic            last;
    logic [31:0]     mag_full;
    logic [MW-1:0]   mag;
    logic            s;
    logic [MW-1:0]   min1_nxt;
    logic [MW-1:0]   min2_nxt;
    logic [IDXW-1:0] idx_nxt;

    function automatic logic [MW-1:0] sat_sub(input logic [MW-1:0] v);
`ifdef OFFSET_MINSUM_EN
        if (int'(v) > OFFSET)
            return v - MW'(OFFSET);
        else
            return '0;
`else
        return v;
`endif
    endfunction

    assign accept   = in_valid && in_ready;
    assign mag_full = mag_of(32'(in_msg), W);
    assign mag      = mag_full[MW-1:0];
    assign s        = in_msg[W-1];
    assign last     = (state == ACC) && (count == IDXW'(DC - 1));

    cnu_min_update #(
        .MW   (MW),
        .IDXW (IDXW)
    ) u_min_update (
        .min1     (min1),
        .min2     (min2),
        .idx      (idx),
        .mag      (mag),
        .p        (count),
        .min1_nxt (min1_nxt),
        .min2_nxt (min2_nxt),
        .idx_nxt  (idx_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = ACC;
            ACC:  if (accept && last) state_nxt = HOLD;
            HOLD: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state != HOLD);
        out_valid = (state == HOLD);
        busy      = (state == ACC);
    end

    // Result registers capture the final beat's combinational update directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            min1     <= '0;
            min2     <= '0;
            idx      <= '0;
            sign     <= 1'b0;
            out_min1 <= '0;
            out_min2 <= '0;
            out_idx  <= '0;
            out_sign <= 1'b0;
        end else if (accept) begin
            unique case (state)
                IDLE: begin
                    min1  <= mag;
                    min2  <= '1;
                    idx   <= '0;
                    sign  <= s;
                    count <= IDXW'(1);
                end
                ACC: begin
                    min1  <= min1_nxt;
                    min2  <= min2_nxt;
                    idx   <= idx_nxt;
                    sign  <= sign ^ s;
                    count <= last ? '0 : count + 1'b1;
                    if (last) begin
                        out_min1 <= sat_sub(min1_nxt);
                        out_min2 <= sat_sub(min2_nxt);
                        out_idx  <= idx_nxt;
                        out_sign <= sign ^ s;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnu_serial_row_ctrl.sv
// Directed plus randomized bench for cnu_serial_row_ctrl (W=6, DC=8).
// Expected row results are queued at stimulus time and popped at HOLD.
module tb_cnu_serial_row_ctrl;

    localparam int W      = 6;
    localparam int DC     = 8;
    localparam int IDXW   = 3;
    localparam int OFFSET = 1;

    typedef struct {
        int min1;
        int min2;
        int idx;
        int sign;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_msg = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-2:0]    out_min1;
    logic [W-2:0]    out_min2;
    logic [IDXW-1:0] out_idx;
    logic            out_sign;
    logic            busy;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    cnu_serial_row_ctrl #(
        .W(W), .DC(DC), .IDXW(IDXW), .OFFSET(OFFSET)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_msg    (in_msg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_min1  (out_min1),
        .out_min2  (out_min2),
        .out_idx   (out_idx),
        .out_sign  (out_sign),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] mk(input int s, input int m);
        return {1'(s), 5'(m)};
    endfunction

    function automatic int off(input int v);
`ifdef OFFSET_MINSUM_EN
        return (v > OFFSET) ? v - OFFSET : 0;
`else
        return v;
`endif
    endfunction

    // Reference: first position of the minimum, then min over the others.
    function automatic exp_t model(input logic [W-1:0] m[DC]);
        exp_t e;
        int   mn;
        int   mi;
        int   m2;
        int   sg;
        mn = 1000;
        mi = 0;
        sg = 0;
        for (int i = 0; i < DC; i++) begin
            sg ^= int'(m[i][W-1]);
            if (int'(m[i][W-2:0]) < mn) begin
                mn = int'(m[i][W-2:0]);
                mi = i;
            end
        end
        m2 = 1000;
        for (int i = 0; i < DC; i++)
            if (i != mi && int'(m[i][W-2:0]) < m2)
                m2 = int'(m[i][W-2:0]);
        e.min1 = off(mn);
        e.min2 = off(m2);
        e.idx  = mi;
        e.sign = sg;
        return e;
    endfunction

    task automatic send_beat(input logic [W-1:0] msg, input int gapmax,
                             input bit rnd_ready);
        int g;
        g = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
        for (int k = 0; k < g; k++) begin
            in_valid = 1'b0;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b1;
        in_msg   = msg;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_row(input logic [W-1:0] m[DC], input int gapmax,
                            input bit rnd_ready);
        sb.push_back(model(m));
        for (int i = 0; i < DC; i++) begin
            send_beat(m[i], gapmax, rnd_ready);
            if (i < DC - 1)
                chk("early_valid", 32'(out_valid), 0);
        end
        out_ready = 1'b0;
        chk("latency", 32'(out_valid), 1);
    endtask

    task automatic collect(input int hold, input bit stable, input bit feed);
        exp_t e;
        logic [W-2:0] h1;
        logic [W-2:0] h2;
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            tick();
            t++;
        end
        chk("out_valid_wait", 32'(out_valid), 1);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(out_valid), 0);
        end else begin
            e = sb.pop_front();
            chk("min1", 32'(out_min1), 32'(e.min1));
            chk("min2", 32'(out_min2), 32'(e.min2));
            chk("idx", 32'(out_idx), 32'(e.idx));
            chk("sign", 32'(out_sign), 32'(e.sign));
        end
        h1 = out_min1;
        h2 = out_min2;
        if (feed) begin
            in_valid = 1'b1;
            in_msg   = mk(0, 0);
        end
        for (int k = 0; k < hold; k++) begin
            tick();
            if (stable) begin
                chk("hold_min1", 32'(out_min1), 32'(h1));
                chk("hold_min2", 32'(out_min2), 32'(h2));
                chk("hold_in_ready", 32'(in_ready), 0);
                chk("hold_valid", 32'(out_valid), 1);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release_valid", 32'(out_valid), 0);
        chk("release_busy", 32'(busy), 0);
    endtask

    logic [W-1:0] row[DC];

    initial begin
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_min1", 32'(out_min1), 0);
        chk("rst_idx", 32'(out_idx), 0);
        rst = 1'b0;
        tick();

        row = '{mk(1, 5), mk(0, 3), mk(0, 7), mk(1, 3),
                mk(0, 9), mk(0, 1), mk(1, 4), mk(0, 6)};
        send_row(row, 0, 1'b0);
        collect(0, 1'b0, 1'b0);

        for (int i = 0; i < DC; i++) row[i] = mk(i % 2, 4);
        send_row(row, 0, 1'b0);
        collect(0, 1'b0, 1'b0);

        row = '{mk(0, 12), mk(1, 20), mk(0, 6), mk(1, 30),
                mk(0, 7), mk(1, 11), mk(0, 19), mk(0, 8)};
        send_row(row, 0, 1'b0);
        collect(5, 1'b1, 1'b1);
        row = '{mk(1, 2), mk(1, 2), mk(0, 9), mk(0, 31),
                mk(1, 1), mk(0, 2), mk(0, 3), mk(1, 0)};
        send_row(row, 0, 1'b0);
        collect(0, 1'b0, 1'b0);

        send_beat(mk(1, 1), 0, 1'b0);
        send_beat(mk(1, 1), 0, 1'b0);
        send_beat(mk(0, 1), 0, 1'b0);
        chk("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        tick();
        rst = 1'b0;
        row = '{mk(0, 8), mk(0, 8), mk(1, 2), mk(0, 8),
                mk(0, 8), mk(0, 8), mk(0, 8), mk(0, 8)};
        send_row(row, 0, 1'b0);
        collect(0, 1'b0, 1'b0);

        row = '{mk(0, 9), mk(1, 2), mk(0, 5), mk(0, 7),
                mk(1, 3), mk(0, 6), mk(0, 4), mk(1, 0)};
        send_row(row, 0, 1'b0);
        collect(0, 1'b0, 1'b0);

        for (int r = 0; r < 1000; r++) begin
            for (int i = 0; i < DC; i++)
                row[i] = W'($urandom_range(0, 63));
            send_row(row, 3, 1'b1);
            collect($urandom_range(0, 2), 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
